// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command master: frame geometry, opcodes, FSM states.
package spi_cmd_pkg;
  localparam int OPC_W     = 8;
  localparam int PAYLOAD_W = 128;
  localparam int FRAME_LEN = OPC_W + PAYLOAD_W;

  localparam logic [OPC_W-1:0] OPC_EXCITE_DD  = 8'd1;
  localparam logic [OPC_W-1:0] OPC_EXCITE_XOR = 8'd2;
  localparam logic [OPC_W-1:0] OPC_READ_DD    = 8'd3;
  localparam logic [OPC_W-1:0] OPC_READ_XOR   = 8'd4;

  typedef enum logic [2:0] {IDLE, LEAD, LO, HI, TAIL, GAP} state_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 master sending fixed-length opcode+payload frames MSB first,
// capturing MISO full-duplex into RX_DATA.
module spi_cmd_master #(
  parameter int FRAME_LEN = spi_cmd_pkg::FRAME_LEN,
  parameter int CLK_DIV   = 2,
  parameter int LEAD_CYC  = 4,
  parameter int TAIL_CYC  = 4,
  parameter int GAP_CYC   = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [FRAME_LEN-1:0] CMD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [FRAME_LEN-1:0] RX_DATA,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic                 SSEL,
  input  logic                 MISO
);
  import spi_cmd_pkg::*;

  localparam int BCW  = $clog2(FRAME_LEN + 1);
  localparam int CMAX = max_of4(LEAD_CYC, CLK_DIV, TAIL_CYC, GAP_CYC);
  localparam int CW   = $clog2(CMAX + 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BCW-1:0]       bitcnt;
  // MSB of the frame lives in MOSI itself, so the shifter holds only the rest.
  logic [FRAME_LEN-2:0] tx_sh;
  logic [FRAME_LEN-1:0] rx_sh;
  logic                 miso_s;

  sync_2ff u_miso_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (MISO),
    .q     (miso_s)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      bitcnt  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      RX_DATA <= '0;
      SSEL    <= 1'b1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          state  <= LEAD;
          cnt    <= CW'(LEAD_CYC - 1);
          bitcnt <= '0;
          tx_sh  <= CMD[FRAME_LEN-2:0];
          rx_sh  <= '0;
          SSEL   <= 1'b0;
          SCLK   <= 1'b0;
          MOSI   <= CMD[FRAME_LEN-1];
          BUSY   <= 1'b1;
        end
        LEAD: if (cnt == '0) begin
          state <= LO;
          cnt   <= CW'(CLK_DIV - 1);
        end else cnt <= cnt - CW'(1);
        LO: if (cnt == '0) begin
          state <= HI;
          cnt   <= CW'(CLK_DIV - 1);
          SCLK  <= 1'b1;
        end else cnt <= cnt - CW'(1);
        HI: if (cnt == '0) begin
          rx_sh <= {rx_sh[FRAME_LEN-2:0], miso_s};
          SCLK  <= 1'b0;
          if (bitcnt == BCW'(FRAME_LEN - 1)) begin
            state <= TAIL;
            cnt   <= CW'(TAIL_CYC - 1);
          end else begin
            state  <= LO;
            cnt    <= CW'(CLK_DIV - 1);
            bitcnt <= bitcnt + BCW'(1);
            MOSI   <= tx_sh[FRAME_LEN-2];
            tx_sh  <= {tx_sh[FRAME_LEN-3:0], 1'b0};
          end
        end else cnt <= cnt - CW'(1);
        TAIL: if (cnt == '0) begin
          state   <= GAP;
          cnt     <= CW'(GAP_CYC - 1);
          SSEL    <= 1'b1;
          MOSI    <= 1'b0;
          DONE    <= 1'b1;
          RX_DATA <= rx_sh;
        end else cnt <= cnt - CW'(1);
        GAP: if (cnt == '0) begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule
